hart_monitor: RTL and testbench
===============================

# hart_monitor

Parametrised run-control monitor for the single-hart core. It sequences reset, free-run, halt, single-step and error states from the core's interrupt vector, and gates PC write-enable so a trapping instruction never advances the PC. It also latches trap cause and PC and keeps cycle/retired-instruction counters, with an optional PC-stall watchdog. It sits between the PC register, the CPU and the seven-segment display driver.

## Interface
- DATA_WIDTH, 64, PC width
- IRQ_WIDTH, 6, width of the interrupt vector from the CPU
- ERR_MASK, 6'b001111, bit set means that interrupt source is an error (goes to ERROR); clear means trap (goes to HALT)
- CNT_WIDTH, 32, width of cycle and instret counters
- WDT_LIMIT, 1024, consecutive stalled RUN cycles before watchdog fires (>=2)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- interrupts_i  in  IRQ_WIDTH  interrupt/exception vector from CPU, bit 0 highest priority
- pc_i  in  DATA_WIDTH  current PC
- step_mode_i  in  1  sampled in RST: 1 = come out of reset halted
- run_i  in  1  resume request, acted on only in HALT
- step_i  in  1  single-step request, acted on only in HALT
- pc_we_o  out  1  PC register write enable (combinational)
- state_o  out  3  current state: RST=0, RUN=1, HALT=2, ERROR=3, STEP=4
- cause_o  out  $clog2(IRQ_WIDTH+1)  latched cause; value IRQ_WIDTH = watchdog
- trap_pc_o  out  DATA_WIDTH  PC latched at trap/error
- cycle_o  out  CNT_WIDTH  cycles spent in RUN or STEP
- instret_o  out  CNT_WIDTH  cycles with pc_we_o=1

## Operation
- Active = state is RUN or STEP. pc_we_o = active AND interrupts_i==0.
- Trap condition (active states only): err = |(interrupts_i & ERR_MASK); trap = |interrupts_i.
- RST: next RUN if step_mode_i=0, else HALT.
- RUN: err -> ERROR; else trap -> HALT; else watchdog fire -> ERROR; else RUN.
- STEP: err -> ERROR; else trap -> HALT; else -> HALT (exactly one PC write).
- HALT: run_i -> RUN; else step_i -> STEP; else HALT. run_i wins if both high.
- ERROR: sticky; only rst_i leaves.
- Interrupts ignored in RST, HALT, ERROR.
- On any active->HALT/ERROR edge caused by interrupts: cause_o <= index of lowest set bit of interrupts_i, trap_pc_o <= pc_i. STEP->HALT with no interrupt does not update them.
- Counters: cycle_o +1 each active cycle; instret_o +1 each cycle pc_we_o=1; both wrap modulo 2^CNT_WIDTH, no saturation; frozen outside active states.

## Timing
- state_o, cause_o, trap_pc_o, counters registered, update on the edge ending the evaluating cycle; pc_we_o is same-cycle combinational (zero latency gate of faulting instruction).
- Reset (any cycle, including mid-step or mid-watchdog count): state_o=0, cause_o=0, trap_pc_o=0, cycle_o=0, instret_o=0, watchdog count=0; pc_we_o=0 while in RST.
- First RUN cycle is the second cycle after rst_i deasserts.
- HALT->RUN/STEP takes one edge; STEP occupies exactly one cycle.

## Configuration
- MONITOR_WDT_EN defined: watchdog present. Stall counter +1 each RUN cycle where pc_i equals previous-cycle pc_i, cleared on any PC change or non-RUN cycle. If it holds WDT_LIMIT-1 and increments this cycle, fire: next state ERROR, cause_o<=IRQ_WIDTH, trap_pc_o<=pc_i. Interrupts in that same cycle take priority.
- Undefined: no stall counter or previous-PC register; watchdog never fires; cause_o never equals IRQ_WIDTH.

## Test plan
- Reset, step_mode_i=0, interrupts 0 for 10 cycles -> state 0,1,1,...; pc_we_o=1 from cycle 2; cycle_o=instret_o=9 after 10 cycles post-reset.
- In RUN at pc_i=0x80000010 assert interrupts_i=6'b100000 (EBREAK) -> pc_we_o=0 same cycle; next state HALT, cause_o=5, trap_pc_o=0x80000010.
- In RUN assert interrupts_i=6'b000110 -> ERROR, cause_o=1; then run_i/step_i pulses -> stays ERROR until rst_i.
- Reset with step_mode_i=1 -> HALT; pulse step_i 3 times -> 3 STEP cycles, instret_o=3; run_i and step_i together -> RUN.
- MONITOR_WDT_EN, WDT_LIMIT=4, hold pc_i constant in RUN -> ERROR after 4 stalled cycles, cause_o=6; with macro undefined stays RUN indefinitely.
- Force cycle_o near 2^CNT_WIDTH-1 (CNT_WIDTH=4 build) -> wraps to 0 after 16 active cycles; rst_i asserted during STEP -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/hart_monitor.sv
// rtl/hart_monitor.sv - run-control monitor: state sequencing, PC write gating, trap latch, counters
// Optional PC-stall watchdog enabled by defining MONITOR_WDT_EN.
module hart_monitor #(
    parameter int                   DATA_WIDTH = 64,
    parameter int                   IRQ_WIDTH  = 6,
    parameter logic [IRQ_WIDTH-1:0] ERR_MASK   = 6'b001111,
    parameter int                   CNT_WIDTH  = 32,
    parameter int                   WDT_LIMIT  = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [IRQ_WIDTH-1:0]           interrupts_i,
    input  logic [DATA_WIDTH-1:0]          pc_i,
    input  logic                           step_mode_i,
    input  logic                           run_i,
    input  logic                           step_i,
    output logic                           pc_we_o,
    output logic [2:0]                     state_o,
    output logic [$clog2(IRQ_WIDTH+1)-1:0] cause_o,
    output logic [DATA_WIDTH-1:0]          trap_pc_o,
    output logic [CNT_WIDTH-1:0]           cycle_o,
    output logic [CNT_WIDTH-1:0]           instret_o
);
    localparam int CW = $clog2(IRQ_WIDTH + 1);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_RUN   = 3'd1,
        ST_HALT  = 3'd2,
        ST_ERROR = 3'd3,
        ST_STEP  = 3'd4
    } state_t;

    state_t          state, state_n;
    logic            active, err, trap, wdt_fire, latch;
    logic [CW-1:0]   irq_idx, cause_n;

    assign active  = (state == ST_RUN) || (state == ST_STEP);
    assign err     = |(interrupts_i & ERR_MASK);
    assign trap    = |interrupts_i;
    assign pc_we_o = active && !trap;
    assign state_o = state;

    // Lowest set bit wins: bit 0 is the highest-priority source.
    always_comb begin
        irq_idx = '0;
        for (int i = IRQ_WIDTH - 1; i >= 0; i--) begin
            if (interrupts_i[i]) irq_idx = CW'(i);
        end
    end

`ifdef MONITOR_WDT_EN
    localparam int SW = $clog2(WDT_LIMIT + 1);
    logic [SW-1:0]         stall_cnt;
    logic [DATA_WIDTH-1:0] prev_pc;
    logic                  stalled;

    assign stalled  = (state == ST_RUN) && (pc_i == prev_pc);
    assign wdt_fire = stalled && (stall_cnt == SW'(WDT_LIMIT - 1));

    // prev_pc tracks pc_i every cycle; only the count needs clearing on reset.
    always_ff @(posedge clk_i) begin
        prev_pc <= pc_i;
        if (rst_i || !stalled) stall_cnt <= '0;
        else                   stall_cnt <= stall_cnt + SW'(1);
    end
`else
    assign wdt_fire = 1'b0 & (WDT_LIMIT == 0);
`endif

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        cause_n = irq_idx;
        case (state)
            ST_RST:  state_n = step_mode_i ? ST_HALT : ST_RUN;
            ST_RUN, ST_STEP: begin
                if (err) begin
                    state_n = ST_ERROR;
                    latch   = 1'b1;
                end else if (trap) begin
                    state_n = ST_HALT;
                    latch   = 1'b1;
                end else if (wdt_fire) begin
                    state_n = ST_ERROR;
                    latch   = 1'b1;
                    cause_n = CW'(IRQ_WIDTH);
                end else if (state == ST_STEP) begin
                    state_n = ST_HALT;
                end
            end
            ST_HALT: begin
                if (run_i)       state_n = ST_RUN;
                else if (step_i) state_n = ST_STEP;
            end
            ST_ERROR: state_n = ST_ERROR;
            default:  state_n = ST_RST;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_RST;
            cause_o   <= '0;
            trap_pc_o <= '0;
            cycle_o   <= '0;
            instret_o <= '0;
        end else begin
            state <= state_n;
            if (latch) begin
                cause_o   <= cause_n;
                trap_pc_o <= pc_i;
            end
            if (active)  cycle_o   <= cycle_o + CNT_WIDTH'(1);
            if (pc_we_o) instret_o <= instret_o + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_hart_monitor.sv
// tb/tb_hart_monitor.sv - scoreboard bench for hart_monitor (CNT_WIDTH=4, WDT_LIMIT=4)
module tb_hart_monitor;
    localparam int DW = 64;
    localparam int IW = 6;
    localparam int NW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [IW-1:0] interrupts_i = '0;
    logic [DW-1:0] pc_i = '0;
    logic          step_mode_i = 1'b0;
    logic          run_i = 1'b0;
    logic          step_i = 1'b0;
    logic          pc_we_o;
    logic [2:0]    state_o;
    logic [2:0]    cause_o;
    logic [DW-1:0] trap_pc_o;
    logic [NW-1:0] cycle_o;
    logic [NW-1:0] instret_o;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_s;

    hart_monitor #(.DATA_WIDTH(DW), .IRQ_WIDTH(IW), .ERR_MASK(6'b001111),
                   .CNT_WIDTH(NW), .WDT_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .interrupts_i(interrupts_i), .pc_i(pc_i),
        .step_mode_i(step_mode_i), .run_i(run_i), .step_i(step_i),
        .pc_we_o(pc_we_o), .state_o(state_o), .cause_o(cause_o),
        .trap_pc_o(trap_pc_o), .cycle_o(cycle_o), .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; step_mode_i = 1'b0; pc_i = 64'h0;
        tick();
        tick();
        total++;
        if (state_o !== 3'd0 || cause_o !== 3'd0 || trap_pc_o !== '0 || cycle_o !== '0 || instret_o !== '0 || pc_we_o !== 1'b0) begin
            bad++;
            $display("FAIL reset: state=%0d cause=%0d trap_pc=%h cycle=%0d instret=%0d pc_we=%b, required all 0",
                     state_o, cause_o, trap_pc_o, cycle_o, instret_o, pc_we_o);
        end
    endtask

    task automatic test_run;
        rst_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            pc_i = 64'h1000 + 64'(4 * k);
            exp_q.push_back(3'd1);
            #1;
            total++;
            if (pc_we_o !== (k > 1)) begin
                bad++;
                $display("FAIL run_pc_we cycle %0d: got %b want %b", k, pc_we_o, (k > 1));
            end
            total++;
            if (state_o !== ((k > 1) ? 3'd1 : 3'd0)) begin
                bad++;
                $display("FAIL run_state_before cycle %0d: got %0d", k, state_o);
            end
            tick();
            exp_s = exp_q.pop_front();
            total++;
            if (state_o !== exp_s) begin
                bad++;
                $display("FAIL run_state cycle %0d: got %0d want %0d", k, state_o, exp_s);
            end
        end
        total++;
        if (cycle_o !== 4'd9 || instret_o !== 4'd9) begin
            bad++;
            $display("FAIL run_counters: cycle=%0d instret=%0d want 9/9", cycle_o, instret_o);
        end
    endtask

    task automatic test_trap;
        pc_i = 64'h8000_0010;
        interrupts_i = 6'b100000;
        exp_q.push_back(3'd2);
        #1;
        total++;
        if (pc_we_o !== 1'b0) begin
            bad++;
            $display("FAIL trap_pc_we: got %b want 0", pc_we_o);
        end
        tick();
        interrupts_i = 6'b000001;
        exp_s = exp_q.pop_front();
        total++;
        if (state_o !== exp_s || cause_o !== 3'd5 || trap_pc_o !== 64'h8000_0010) begin
            bad++;
            $display("FAIL trap_latch: state=%0d cause=%0d trap_pc=%h want 2/5/80000010", state_o, cause_o, trap_pc_o);
        end
        total++;
        if (cycle_o !== 4'd10 || instret_o !== 4'd9) begin
            bad++;
            $display("FAIL trap_counters: cycle=%0d instret=%0d want 10/9", cycle_o, instret_o);
        end
        // Interrupts while halted must be ignored.
        for (int k = 0; k < 2; k++) begin
            pc_i = pc_i + 64'd4;
            exp_q.push_back(3'd2);
            tick();
            exp_s = exp_q.pop_front();
            total++;
            if (state_o !== exp_s || cause_o !== 3'd5 || cycle_o !== 4'd10 || pc_we_o !== 1'b0) begin
                bad++;
                $display("FAIL halt_ignore: state=%0d cause=%0d cycle=%0d pc_we=%b", state_o, cause_o, cycle_o, pc_we_o);
            end
        end
        interrupts_i = '0;
    endtask

    task automatic test_error;
        run_i = 1'b1;
        exp_q.push_back(3'd1);
        tick();
        run_i = 1'b0;
        exp_s = exp_q.pop_front();
        total++;
        if (state_o !== exp_s) begin
            bad++;
            $display("FAIL resume: state=%0d want %0d", state_o, exp_s);
        end
        pc_i = 64'h1234;
        interrupts_i = 6'b000110;
        exp_q.push_back(3'd3);
        tick();
        interrupts_i = '0;
        exp_s = exp_q.pop_front();
        total++;
        if (state_o !== exp_s || cause_o !== 3'd1 || trap_pc_o !== 64'h1234) begin
            bad++;
            $display("FAIL error_latch: state=%0d cause=%0d trap_pc=%h want 3/1/1234", state_o, cause_o, trap_pc_o);
        end
        for (int k = 0; k < 4; k++) begin
            run_i  = k[0];
            step_i = ~k[0];
            pc_i   = pc_i + 64'd4;
            exp_q.push_back(3'd3);
            tick();
            exp_s = exp_q.pop_front();
            total++;
            if (state_o !== exp_s || pc_we_o !== 1'b0) begin
                bad++;
                $display("FAIL error_sticky %0d: state=%0d pc_we=%b want 3/0", k, state_o, pc_we_o);
            end
        end
        run_i = 1'b0; step_i = 1'b0;
    endtask

    task automatic test_step;
        rst_i = 1'b1; step_mode_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.push_back(3'd2);
        tick();
        exp_s = exp_q.pop_front();
        total++;
        if (state_o !== exp_s || cycle_o !== '0 || instret_o !== '0) begin
            bad++;
            $display("FAIL step_mode_reset: state=%0d cycle=%0d instret=%0d want 2/0/0", state_o, cycle_o, instret_o);
        end
        for (int k = 0; k < 3; k++) begin
            step_i = 1'b1;
            pc_i   = 64'h100 + 64'(4 * k);
            tick();
            step_i = 1'b0;
            total++;
            if (state_o !== 3'd4 || pc_we_o !== 1'b1) begin
                bad++;
                $display("FAIL step_enter %0d: state=%0d pc_we=%b want 4/1", k, state_o, pc_we_o);
            end
            exp_q.push_back(3'd2);
            tick();
            exp_s = exp_q.pop_front();
            total++;
            if (state_o !== exp_s) begin
                bad++;
                $display("FAIL step_exit %0d: state=%0d want %0d", k, state_o, exp_s);
            end
        end
        total++;
        if (instret_o !== 4'd3 || cycle_o !== 4'd3) begin
            bad++;
            $display("FAIL step_counts: instret=%0d cycle=%0d want 3/3", instret_o, cycle_o);
        end
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        pc_i = 64'h200;
        interrupts_i = 6'b010000;
        exp_q.push_back(3'd2);
        tick();
        interrupts_i = '0;
        exp_s = exp_q.pop_front();
        total++;
        if (state_o !== exp_s || cause_o !== 3'd4 || trap_pc_o !== 64'h200 || instret_o !== 4'd3 || cycle_o !== 4'd4) begin
            bad++;
            $display("FAIL step_trap: state=%0d cause=%0d trap_pc=%h instret=%0d cycle=%0d", state_o, cause_o, trap_pc_o, instret_o, cycle_o);
        end
        run_i = 1'b1; step_i = 1'b1; pc_i = 64'h300;
        exp_q.push_back(3'd1);
        tick();
        run_i = 1'b0; step_i = 1'b0;
        exp_s = exp_q.pop_front();
        total++;
        if (state_o !== exp_s) begin
            bad++;
            $display("FAIL run_wins: state=%0d want %0d", state_o, exp_s);
        end
    endtask

    task automatic test_watchdog;
        pc_i = 64'h500;
        for (int k = 0; k < 20; k++) begin
`ifdef MONITOR_WDT_EN
            if (k < 5) exp_q.push_back((k == 4) ? 3'd3 : 3'd1);
            else       exp_q.push_back(3'd3);
`else
            exp_q.push_back(3'd1);
`endif
            tick();
            exp_s = exp_q.pop_front();
            total++;
            if (state_o !== exp_s) begin
                bad++;
                $display("FAIL watchdog_state %0d: state=%0d want %0d", k, state_o, exp_s);
            end
        end
`ifdef MONITOR_WDT_EN
        total++;
        if (cause_o !== 3'd6 || trap_pc_o !== 64'h500) begin
            bad++;
            $display("FAIL watchdog_cause: cause=%0d trap_pc=%h want 6/500", cause_o, trap_pc_o);
        end
`else
        total++;
        if (cause_o === 3'd6) begin
            bad++;
            $display("FAIL watchdog_cause: cause=%0d must not be 6", cause_o);
        end
`endif
    endtask

    task automatic test_wrap;
        rst_i = 1'b1; step_mode_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        for (int k = 1; k <= 16; k++) begin
            pc_i = 64'h2000 + 64'(4 * k);
            exp_q.push_back(3'd1);
            tick();
            exp_s = exp_q.pop_front();
            total++;
            if (state_o !== exp_s || cycle_o !== 4'(k) || instret_o !== 4'(k)) begin
                bad++;
                $display("FAIL wrap %0d: state=%0d cycle=%0d instret=%0d want %0d", k, state_o, cycle_o, instret_o, 4'(k));
            end
        end
    endtask

    task automatic test_reset_in_step;
        rst_i = 1'b1; step_mode_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        pc_i = 64'h700;
        interrupts_i = 6'b100000;
        tick();
        interrupts_i = '0;
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        total++;
        if (state_o !== 3'd4 || cause_o !== 3'd5 || cycle_o !== 4'd1) begin
            bad++;
            $display("FAIL pre_reset_step: state=%0d cause=%0d cycle=%0d want 4/5/1", state_o, cause_o, cycle_o);
        end
        rst_i = 1'b1;
        tick();
        total++;
        if (state_o !== 3'd0 || cause_o !== 3'd0 || trap_pc_o !== '0 || cycle_o !== '0 || instret_o !== '0 || pc_we_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_step: state=%0d cause=%0d trap_pc=%h cycle=%0d instret=%0d pc_we=%b want all 0",
                     state_o, cause_o, trap_pc_o, cycle_o, instret_o, pc_we_o);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_trap();
        test_error();
        test_step();
        test_watchdog();
        test_wrap();
        test_reset_in_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
